// File: rtl/beamform_pkg.sv
// -----------------------------------------------------------------------------
// beamform_pkg
// Shared definitions for the beamforming chain blocks.
//   COORD_W_DEF / DIST_W_DEF : default coordinate and squared-distance widths
//   CH_W_DEF                 : default channel-index width (16 channels)
//   state_t                  : focal_delay_calc sweep FSM states
//   result_t                 : {ch, dist_sq} record handed to the delay/sqrt stage
// -----------------------------------------------------------------------------
package beamform_pkg;

    localparam int COORD_W_DEF = 16;
    localparam int DIST_W_DEF  = 2 * COORD_W_DEF + 2;
    localparam int CH_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [CH_W_DEF-1:0]   ch;
        logic [DIST_W_DEF-1:0] dist_sq;
    } result_t;

endpackage

// File: rtl/dist_sq_pipe.sv
// -----------------------------------------------------------------------------
// dist_sq_pipe
// Two-stage squared-distance pipeline with a common hold.
//   Stage A: dx = x - fx, dz = z - fz (COORD_W+1 signed, cannot wrap)
//   Stage B: dx*dx + dz*dz, registered as the output payload
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   hold              freeze both stages (downstream stall)
//   in_valid, in_ch   ROM-data valid bit and channel tag for this cycle
//   x, z              ROM coordinates (signed)
//   fx, fz            latched focal point (signed)
//   a_valid           stage A occupancy, used by the top for drain detection
//   out_valid/out_ch/out_dist_sq  output register
// -----------------------------------------------------------------------------
module dist_sq_pipe #(
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 4,
    parameter int DIST_W  = 2 * COORD_W + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hold,
    input  logic                      in_valid,
    input  logic [ADDR_W-1:0]         in_ch,
    input  logic signed [COORD_W-1:0] x,
    input  logic signed [COORD_W-1:0] z,
    input  logic signed [COORD_W-1:0] fx,
    input  logic signed [COORD_W-1:0] fz,
    output logic                      a_valid,
    output logic                      out_valid,
    output logic [ADDR_W-1:0]         out_ch,
    output logic [DIST_W-1:0]         out_dist_sq
);

    logic [ADDR_W-1:0]         a_ch;
    logic signed [COORD_W:0]   dx;
    logic signed [COORD_W:0]   dz;
    logic signed [DIST_W-1:0]  dx_ext;
    logic signed [DIST_W-1:0]  dz_ext;
    logic signed [DIST_W-1:0]  sq_x;
    logic signed [DIST_W-1:0]  sq_z;
    logic [DIST_W-1:0]         sum_sq;

    // Squares are formed at full result width; each is non-negative and at most
    // 2^(2*COORD_W), so the sum fits DIST_W without overflow.
    assign dx_ext = DIST_W'(dx);
    assign dz_ext = DIST_W'(dz);
    assign sq_x   = dx_ext * dx_ext;
    assign sq_z   = dz_ext * dz_ext;
    assign sum_sq = $unsigned(sq_x) + $unsigned(sq_z);

    // Stage A: one-bit-wider differences so extreme coordinates never wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_ch    <= '0;
            dx      <= '0;
            dz      <= '0;
        end else if (!hold) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_ch <= in_ch;
                dx   <= $signed({x[COORD_W-1], x}) - $signed({fx[COORD_W-1], fx});
                dz   <= $signed({z[COORD_W-1], z}) - $signed({fz[COORD_W-1], fz});
            end
        end
    end

    // Stage B: output register; payload only moves when a new result enters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_dist_sq <= '0;
        end else if (!hold) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_ch      <= a_ch;
                out_dist_sq <= sum_sq;
            end
        end
    end

endmodule

// File: rtl/focal_delay_calc.sv
// -----------------------------------------------------------------------------
// focal_delay_calc
// Sweeps all channel addresses into the element-coordinate ROM and streams the
// squared distance of each element from a latched focal point.
// Optional build macro FOCAL_CH_MASK_EN adds a per-channel output mask.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a sweep (accepted only in IDLE, not on done)
//   focal_x, focal_z      focal point, latched on accepted start
//   chan_mask             (FOCAL_CH_MASK_EN only) 1 = emit channel
//   busy, done            sweep in progress / one-cycle completion pulse
//   rom_addr              ROM address (combinational)
//   rom_x, rom_z          ROM data, one cycle after rom_addr
//   out_valid, out_ready  result handshake
//   out_ch, out_dist_sq   result payload
// -----------------------------------------------------------------------------
module focal_delay_calc
    import beamform_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int ADDR_W       = $clog2(NUM_CHANNELS),
    parameter int COORD_W      = COORD_W_DEF,
    parameter int DIST_W       = 2 * COORD_W + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] focal_x,
    input  logic signed [COORD_W-1:0] focal_z,
`ifdef FOCAL_CH_MASK_EN
    input  logic [NUM_CHANNELS-1:0]   chan_mask,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic signed [COORD_W-1:0] rom_x,
    input  logic signed [COORD_W-1:0] rom_z,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_ch,
    output logic [DIST_W-1:0]         out_dist_sq
);

    localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NUM_CHANNELS - 1);

    state_t                    state;
    logic [ADDR_W-1:0]         issue_cnt;
    logic [ADDR_W-1:0]         pend_ch;
    logic                      pend_valid;
    logic signed [COORD_W-1:0] fx;
    logic signed [COORD_W-1:0] fz;
    logic                      stall;
    logic                      keep;
    logic                      last_issue;
    logic                      a_valid;

    assign stall = out_valid & ~out_ready;

    // While stalled the ROM data of the pending address has not been consumed,
    // so re-read that same entry instead of advancing.
    assign rom_addr = stall ? pend_ch : issue_cnt;

`ifdef FOCAL_CH_MASK_EN
    logic [NUM_CHANNELS-1:0] mask_r;

    assign keep = mask_r[pend_ch];
    // Stop issuing once no enabled channel remains above the current one, so an
    // empty mask finishes quickly.
    assign last_issue = (issue_cnt == LAST_CH) || (((mask_r >> issue_cnt) >> 1) == '0);
`else
    assign keep       = 1'b1;
    assign last_issue = (issue_cnt == LAST_CH);
`endif

    // Sweep FSM, issue counter, pending-ROM tag and busy/done outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            fx         <= '0;
            fz         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef FOCAL_CH_MASK_EN
            mask_r     <= '0;
`endif
        end else begin
            if (!stall) begin
                pend_valid <= (state == RUN);
                pend_ch    <= issue_cnt;
            end
            case (state)
                IDLE: begin
                    // The done cycle is spent in IDLE; start is ignored there.
                    if (done) begin
                        done <= 1'b0;
                        busy <= 1'b0;
                    end else if (start) begin
                        fx        <= focal_x;
                        fz        <= focal_z;
                        issue_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
`ifdef FOCAL_CH_MASK_EN
                        mask_r    <= chan_mask;
`endif
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (last_issue) begin
                            issue_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            issue_cnt <= issue_cnt + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Nothing left upstream of the output and the output is
                    // either empty or handshaking this cycle.
                    if (!stall && !pend_valid && !a_valid) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dist_sq_pipe #(
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W),
        .DIST_W  (DIST_W)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (stall),
        .in_valid    (pend_valid & keep),
        .in_ch       (pend_ch),
        .x           (rom_x),
        .z           (rom_z),
        .fx          (fx),
        .fz          (fz),
        .a_valid     (a_valid),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .out_dist_sq (out_dist_sq)
    );

endmodule
